// File: rtl/ahb_lite_master_if.sv
// AHB-Lite bus bundle between a single initiator and the decoder/mux side.
// Carries the address/control phase signals and the data phase signals.
//   master modport: drives haddr, htrans, hsize, hburst, hwrite, hwdata;
//                   samples hready, hrdata, hresp.
//   slave modport:  the mirror image.
interface ahb_lite_master_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic          hwrite;
  logic [DW-1:0] hwdata;
  logic          hready;
  logic [DW-1:0] hrdata;
  logic          hresp;

  modport master (
    output haddr, htrans, hsize, hburst, hwrite, hwdata,
    input  hready, hrdata, hresp
  );

  modport slave (
    input  haddr, htrans, hsize, hburst, hwrite, hwdata,
    output hready, hrdata, hresp
  );
endinterface

// File: rtl/ahb_lite_master.sv
// Single-master AHB-Lite initiator. Turns one command (start address, size,
// beat count, direction) into a pipelined SINGLE or INCR burst, overlapping
// the address phase of each beat with the data phase of the previous one.
// Copes with slave wait states and the two-cycle ERROR response.
// Ports:
//   hclk, hresetn        clock, asynchronous active-low reset
//   cmd_*                command request; accepted when cmd_valid & cmd_ready
//   wdata / wdata_pop    show-ahead write data source and its consume strobe
//   rdata / rdata_valid  one registered pulse per successful read beat
//   done / err           completion pulse, err=1 when aborted by ERROR
//   bus                  AHB-Lite master side
module ahb_lite_master #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int LW = 4
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [LW-1:0]     cmd_len,
  input  logic [DW-1:0]     wdata,
  output logic              wdata_pop,
  output logic [DW-1:0]     rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              err,
  ahb_lite_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_LAST,
    S_ERR
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  state_t        state;
  logic [AW-1:0] haddr_q;
  logic [1:0]    htrans_q;
  logic [2:0]    hsize_q;
  logic [2:0]    hburst_q;
  logic          hwrite_q;
  logic [DW-1:0] hwdata_q;
  logic [LW-1:0] beats_left;
  logic          dphase_valid;
  logic          dphase_write;

  logic          addr_accept;
  logic          dphase_done;
  logic          error_first;

  // An address phase only counts while we are issuing beats and the slave
  // is ready; the data phase of the previously accepted beat ends on the
  // same hready.
  assign addr_accept = (state == S_XFER) && (htrans_q != TR_IDLE) && bus.hready;
  assign dphase_done = dphase_valid && bus.hready;
  assign error_first = dphase_valid && bus.hresp && !bus.hready;

  // The first ERROR cycle must already show IDLE, before the register can
  // react, so htrans is overridden combinationally here.
  assign bus.htrans  = error_first ? TR_IDLE : htrans_q;
  assign bus.haddr   = haddr_q;
  assign bus.hsize   = hsize_q;
  assign bus.hburst  = hburst_q;
  assign bus.hwrite  = hwrite_q;
  assign bus.hwdata  = hwdata_q;

  // The write word is consumed on the edge that accepts its address phase.
  assign wdata_pop   = addr_accept && hwrite_q;

  // Main controller: command capture, beat sequencing, completion and
  // error abort. beats_left counts address phases still to issue after the
  // one currently on the bus; dphase_* tracks the beat in its data phase.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state        <= S_IDLE;
      haddr_q      <= '0;
      htrans_q     <= TR_IDLE;
      hsize_q      <= '0;
      hburst_q     <= '0;
      hwrite_q     <= 1'b0;
      hwdata_q     <= '0;
      beats_left   <= '0;
      dphase_valid <= 1'b0;
      dphase_write <= 1'b0;
      cmd_ready    <= 1'b1;
      rdata        <= '0;
      rdata_valid  <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done        <= 1'b0;
      err         <= 1'b0;
      rdata_valid <= 1'b0;

      if (dphase_done && !dphase_write && !bus.hresp) begin
        rdata       <= bus.hrdata;
        rdata_valid <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            haddr_q    <= cmd_addr;
            hsize_q    <= cmd_size;
            hwrite_q   <= cmd_write;
            hburst_q   <= (cmd_len == '0) ? 3'b000 : 3'b001;
            htrans_q   <= TR_NONSEQ;
            beats_left <= cmd_len;
            cmd_ready  <= 1'b0;
            state      <= S_XFER;
          end
        end

        S_XFER: begin
          if (error_first) begin
            htrans_q     <= TR_IDLE;
            dphase_valid <= 1'b0;
            done         <= 1'b1;
            err          <= 1'b1;
            state        <= S_ERR;
          end else if (addr_accept) begin
            dphase_valid <= 1'b1;
            dphase_write <= hwrite_q;
            if (hwrite_q) begin
              hwdata_q <= wdata;
            end
            if (beats_left == '0) begin
              htrans_q <= TR_IDLE;
              state    <= S_LAST;
            end else begin
              htrans_q   <= TR_SEQ;
              haddr_q    <= haddr_q + (AW'(1) << hsize_q);
              beats_left <= beats_left - LW'(1);
            end
          end
        end

        S_LAST: begin
          if (error_first) begin
            htrans_q     <= TR_IDLE;
            dphase_valid <= 1'b0;
            done         <= 1'b1;
            err          <= 1'b1;
            state        <= S_ERR;
          end else if (dphase_done) begin
            dphase_valid <= 1'b0;
            done         <= 1'b1;
            cmd_ready    <= 1'b1;
            state        <= S_IDLE;
          end
        end

        // Second ERROR cycle: done/err are already showing; leave once the
        // slave completes the response.
        S_ERR: begin
          if (bus.hready) begin
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Testbench for ahb_lite_master. A bench-owned AHB-Lite memory slave with
// programmable wait states and ERROR injection answers the bus; a
// command-level reference model predicts the address sequence, write data,
// read data, strobe counts and completion latency of every command.
module tb_ahb_lite_master;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          hclk = 1'b0;
  logic          hresetn = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [2:0]    cmd_size = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] wdata = '0;
  logic          wdata_pop;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          done;
  logic          err;

  always #5 hclk = ~hclk;

  ahb_lite_master_if #(.AW(AW), .DW(DW)) bus ();

  ahb_lite_master #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_size    (cmd_size),
    .cmd_len     (cmd_len),
    .wdata       (wdata),
    .wdata_pop   (wdata_pop),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .err         (err),
    .bus         (bus)
  );

  int compared = 0;
  int mismatched = 0;

  // Slave memory (written from the bus) and reference memory (written by
  // the command-level model), word indexed.
  logic [31:0] mem     [0:16383];
  logic [31:0] ref_mem [0:16383];

  // Slave data-phase tracking and response plan.
  bit          sp_valid, sp_write, err_second;
  logic [15:0] sp_addr;
  logic [2:0]  sp_size;
  int          sp_beat, beat_count, stall_beat, stall_left, err_beat;

  // Per-command expectations and observations.
  logic [31:0] wq[$];
  logic [31:0] exp_rd[$];
  logic [15:0] exp_addr[$];
  bit          cur_write;
  logic [2:0]  cur_size, cur_burst;
  int          exp_issued, exp_ok, exp_latency;
  int          addr_idx, pop_count, rv_count, done_count;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word, input logic [31:0] new_word,
                                              input logic [15:0] addr, input logic [2:0] size);
    logic [31:0] mask;
    case (size)
      3'd0:    mask = 32'h0000_00FF << (8 * addr[1:0]);
      3'd1:    mask = 32'h0000_FFFF << (16 * addr[1]);
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (old_word & ~mask) | (new_word & mask);
  endfunction

  // First half of a cycle: just after the rising edge, present show-ahead
  // write data and the slave response for the current data phase.
  task automatic cycleBegin();
    @(posedge hclk);
    #1;
    wdata = (pop_count < wq.size()) ? wq[pop_count] : 32'h0;
    bus.hrdata = (sp_valid && !sp_write) ? mem[sp_addr[15:2]] : $urandom;
    if (err_second) begin
      bus.hready = 1'b1; bus.hresp = 1'b1;
    end else if (sp_valid && err_beat != 0 && sp_beat + 1 == err_beat) begin
      bus.hready = 1'b0; bus.hresp = 1'b1;
    end else if (sp_valid && sp_beat + 1 == stall_beat && stall_left > 0) begin
      bus.hready = 1'b0; bus.hresp = 1'b0;
      stall_left--;
    end else begin
      bus.hready = 1'b1; bus.hresp = 1'b0;
    end
  endtask

  // Second half: on the falling edge, observe and check the bus, then
  // advance the slave as the coming rising edge will.
  task automatic cycleEnd();
    logic [31:0] exp_trans;
    @(negedge hclk);
    if (wdata_pop) pop_count++;
    if (done) done_count++;
    if (rdata_valid) begin
      if (rv_count < exp_rd.size()) checkOutput("rdata", rdata, exp_rd[rv_count]);
      else checkOutput("rdata_extra", 32'(rdata_valid), 32'h0);
      rv_count++;
    end
    if (!bus.hready && bus.hresp) checkOutput("htrans_first_err", 32'(bus.htrans), 32'h0);
    if (bus.htrans != 2'b00) begin
      if (addr_idx < exp_addr.size()) begin
        exp_trans = (addr_idx == 0) ? 32'h2 : 32'h3;
        checkOutput("haddr", 32'(bus.haddr), 32'(exp_addr[addr_idx]));
        checkOutput("htrans", 32'(bus.htrans), exp_trans);
        checkOutput("hsize", 32'(bus.hsize), 32'(cur_size));
        checkOutput("hwrite", 32'(bus.hwrite), 32'(cur_write));
        checkOutput("hburst", 32'(bus.hburst), 32'(cur_burst));
      end else begin
        checkOutput("extra_addr", 32'(bus.htrans), 32'h0);
      end
      if (bus.hready) addr_idx++;
    end
    if (sp_valid && sp_write && sp_beat < wq.size()) checkOutput("hwdata", bus.hwdata, wq[sp_beat]);
    if (bus.hready) begin
      if (sp_valid && sp_write && !bus.hresp)
        mem[sp_addr[15:2]] = merge_lanes(mem[sp_addr[15:2]], bus.hwdata, sp_addr, sp_size);
      if (bus.htrans[1]) begin
        sp_valid = 1'b1; sp_write = bus.hwrite; sp_addr = bus.haddr; sp_size = bus.hsize;
        sp_beat = beat_count; beat_count++;
      end else begin
        sp_valid = 1'b0;
      end
      err_second = 1'b0;
    end else if (bus.hresp) begin
      err_second = 1'b1;
    end
  endtask

  // Command-level reference model: beat i sits at addr + i*2^size; an ERROR
  // on beat k stops issue after k beats and leaves k-1 good beats; each
  // beat costs one cycle, plus acceptance, final data phase and done.
  task automatic planCommand(input bit wr, input logic [15:0] addr, input logic [2:0] size, input logic [3:0] len,
                             input int s_beat, input int s_len, input int e_beat,
                             input bit fixed_en, input logic [31:0] fixed_word);
    int beats, stall_cycles;
    logic [15:0] a;
    beats = int'(len) + 1;
    exp_addr.delete(); wq.delete(); exp_rd.delete();
    for (int i = 0; i < beats; i++) begin
      exp_addr.push_back(addr + 16'(i << size));
      wq.push_back($urandom);
    end
    if (fixed_en) wq[0] = fixed_word;
    exp_issued   = (e_beat != 0) ? e_beat : beats;
    exp_ok       = (e_beat != 0) ? e_beat - 1 : beats;
    stall_cycles = (s_beat > 0 && s_beat <= exp_ok) ? s_len : 0;
    exp_latency  = exp_issued + 2 + stall_cycles;
    if (!wr) begin
      for (int i = 0; i < exp_ok; i++) begin
        a = exp_addr[i];
        exp_rd.push_back(ref_mem[a[15:2]]);
      end
    end
    cur_write = wr; cur_size = size; cur_burst = (len == 4'd0) ? 3'b000 : 3'b001;
    stall_beat = s_beat; stall_left = s_len; err_beat = e_beat; beat_count = 0;
    addr_idx = 0; pop_count = 0; rv_count = 0; done_count = 0;
  endtask

  task automatic applyStimulus(input bit wr, input logic [15:0] addr, input logic [2:0] size, input logic [3:0] len,
                               input int s_beat, input int s_len, input int e_beat,
                               input bit fixed_en, input logic [31:0] fixed_word);
    int cyc;
    logic [15:0] a;
    planCommand(wr, addr, size, len, s_beat, s_len, e_beat, fixed_en, fixed_word);
    cycleBegin();
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_len = len;
    cycleEnd();
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'h1);
    cyc = 0;
    while (done_count == 0 && cyc < 300) begin
      cycleBegin();
      cmd_valid = 1'b0;
      cycleEnd();
      cyc++;
      if (done_count == 0) checkOutput("cmd_ready_busy", 32'(cmd_ready), 32'h0);
    end
    if (done_count == 0) begin
      checkOutput("done_timeout", 32'(done), 32'h1);
    end else begin
      checkOutput("done_latency", 32'(cyc), 32'(exp_latency));
      checkOutput("err_flag", 32'(err), 32'(e_beat != 0));
    end
    cycleBegin(); cycleEnd();
    checkOutput("cmd_ready_after", 32'(cmd_ready), 32'h1);
    cycleBegin(); cycleEnd();
    checkOutput("beats_issued", 32'(addr_idx), 32'(exp_issued));
    checkOutput("wdata_pops", 32'(pop_count), wr ? 32'(exp_issued) : 32'h0);
    checkOutput("rdata_count", 32'(rv_count), wr ? 32'h0 : 32'(exp_ok));
    checkOutput("done_count", 32'(done_count), 32'h1);
    if (wr) begin
      for (int i = 0; i < exp_ok; i++) begin
        a = exp_addr[i];
        ref_mem[a[15:2]] = merge_lanes(ref_mem[a[15:2]], wq[i], a, size);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          wr;
    logic [2:0]  sz;
    logic [3:0]  ln;
    logic [15:0] ad;
    int          off, eb, sb, sl;

    bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;
    sp_valid = 0; sp_write = 0; err_second = 0; sp_addr = '0; sp_size = '0;
    sp_beat = 0; beat_count = 0; stall_beat = 0; stall_left = 0; err_beat = 0;
    addr_idx = 0; pop_count = 0; rv_count = 0; done_count = 0;
    cur_write = 0; cur_size = '0; cur_burst = '0;
    for (int i = 0; i < 16384; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end

    // Asynchronous reset before any clock edge.
    #2 hresetn = 1'b0;
    #2;
    checkOutput("rst_htrans", 32'(bus.htrans), 32'h0);
    checkOutput("rst_haddr", 32'(bus.haddr), 32'h0);
    checkOutput("rst_hsize", 32'(bus.hsize), 32'h0);
    checkOutput("rst_hburst", 32'(bus.hburst), 32'h0);
    checkOutput("rst_hwrite", 32'(bus.hwrite), 32'h0);
    checkOutput("rst_hwdata", bus.hwdata, 32'h0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    checkOutput("rst_wdata_pop", 32'(wdata_pop), 32'h0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_rdata_valid", 32'(rdata_valid), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    repeat (3) @(negedge hclk);
    hresetn = 1'b1;

    // Directed cases.
    applyStimulus(1'b1, 16'h0010, 3'd2, 4'd0, 0, 0, 0, 1'b1, 32'hDEADBEEF);
    applyStimulus(1'b0, 16'h0010, 3'd2, 4'd0, 0, 0, 0, 1'b0, 32'h0);
    applyStimulus(1'b0, 16'h0100, 3'd2, 4'd3, 0, 0, 0, 1'b0, 32'h0);
    applyStimulus(1'b1, 16'h0021, 3'd0, 4'd2, 0, 0, 0, 1'b0, 32'h0);
    applyStimulus(1'b1, 16'h0200, 3'd2, 4'd3, 2, 2, 0, 1'b0, 32'h0);
    applyStimulus(1'b0, 16'h0200, 3'd2, 4'd3, 0, 0, 0, 1'b0, 32'h0);
    applyStimulus(1'b0, 16'h0100, 3'd2, 4'd3, 0, 0, 2, 1'b0, 32'h0);

    // Reset in the middle of an INCR4 write.
    planCommand(1'b1, 16'h3000, 3'd2, 4'd3, 0, 0, 0, 1'b0, 32'h0);
    cycleBegin();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h3000; cmd_size = 3'd2; cmd_len = 4'd3;
    cycleEnd();
    cycleBegin(); cmd_valid = 1'b0; cycleEnd();
    cycleBegin(); cycleEnd();
    #2 hresetn = 1'b0;
    #1;
    checkOutput("midrst_htrans", 32'(bus.htrans), 32'h0);
    checkOutput("midrst_haddr", 32'(bus.haddr), 32'h0);
    checkOutput("midrst_hwdata", bus.hwdata, 32'h0);
    checkOutput("midrst_wdata_pop", 32'(wdata_pop), 32'h0);
    checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'h1);
    checkOutput("midrst_done", 32'(done), 32'h0);
    sp_valid = 0; err_second = 0; stall_left = 0; err_beat = 0;
    bus.hready = 1'b1; bus.hresp = 1'b0;
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    cycleBegin(); cycleEnd();
    checkOutput("postrst_cmd_ready", 32'(cmd_ready), 32'h1);
    checkOutput("postrst_done", 32'(done), 32'h0);
    applyStimulus(1'b1, 16'h0300, 3'd2, 4'd3, 0, 0, 0, 1'b0, 32'h0);
    applyStimulus(1'b0, 16'h0300, 3'd2, 4'd3, 0, 0, 0, 1'b0, 32'h0);

    // Randomized commands with occasional wait states and ERROR responses.
    for (int n = 0; n < 30; n++) begin
      wr  = 1'($urandom_range(0, 1));
      sz  = 3'($urandom_range(0, 2));
      ln  = 4'($urandom_range(0, 15));
      off = int'($urandom_range(0, 960)) & ~((1 << sz) - 1);
      ad  = 16'(int'($urandom_range(0, 3)) * 1024 + off);
      eb = 0; sb = 0; sl = 0;
      if ($urandom_range(0, 3) == 0) eb = int'($urandom_range(1, int'(ln) + 1));
      if ($urandom_range(0, 2) == 0) begin
        sl = int'($urandom_range(1, 3));
        if (eb == 0) sb = int'($urandom_range(1, int'(ln) + 1));
        else if (eb > 1) sb = int'($urandom_range(1, eb - 1));
      end
      applyStimulus(wr, ad, sz, ln, sb, sl, eb, 1'b0, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Single-master AHB-Lite initiator. Converts a simple command/data interface into pipelined AHB-Lite SINGLE/INCR transfers, with the address phase of beat n+1 overlapping the data phase of beat n.
- Drives the team's AHB-Lite slaves (RAM, peripherals) through the bus decoder and mux.
- Handles slave wait states (hready low) and two-cycle ERROR responses.

Parameters:
- AW, 16, address width
- DW, 32, data width (fixed 32; hsize ≤ 3'b010)
- LW, 4, burst-length field width (max 2^LW beats)

Ports:
- hclk  in  1  clock
- hresetn  in  1  reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid & ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  AW  start address, aligned to cmd_size
- cmd_size  in  3  0=byte, 1=half, 2=word
- cmd_len  in  LW  beats-1
- wdata  in  DW  write data, show-ahead; valid whenever wdata_pop is high
- wdata_pop  out  1  consume one write word
- rdata  out  DW  read data
- rdata_valid  out  1  one pulse per completed read beat
- done  out  1  one-cycle pulse at command completion
- err  out  1  qualifies done; 1 = aborted by ERROR
- haddr  out  AW
- htrans  out  2  IDLE=00, NONSEQ=10, SEQ=11 (BUSY never used)
- hsize  out  3
- hburst  out  3  SINGLE=000 when cmd_len=0, else INCR=001
- hwrite  out  1
- hwdata  out  DW
- hready  in  1  bus-level ready
- hrdata  in  DW
- hresp  in  1  0=OKAY, 1=ERROR

Behaviour:
- Reset is asynchronous, active-low on hresetn; clock is hclk.
- Reset values: htrans=00, haddr=0, hsize=0, hburst=0, hwrite=0, hwdata=0, cmd_ready=1, wdata_pop=0, rdata=0, rdata_valid=0, done=0, err=0. The FSM goes to IDLE.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch the command, drive htrans=NONSEQ with haddr/hsize/hwrite/hburst from the command, go to XFER. This is a registered output, so the first address phase appears the cycle after acceptance.
  - XFER: an address phase is accepted on a cycle with hready=1 and htrans≠IDLE.
    - Beats remaining after acceptance: next htrans=SEQ, haddr += (1<<hsize).
    - Final beat accepted: next htrans=IDLE, go to LAST.
  - LAST: wait for hready=1 on the final data phase, pulse done (err=0), go to IDLE.
  - ERR: entered on hresp=1 & hready=0 (first ERROR cycle). htrans is forced to IDLE in that same cycle (combinational override) and all remaining beats are cancelled. On the second ERROR cycle (hresp=1 & hready=1), pulse done with err=1, then go to IDLE.
- Address and control are held stable while hready=0.
- haddr increments linearly with no wrap; the caller keeps a burst within a 1 KB boundary.
- Writes:
  - wdata_pop pulses on the cycle a write address phase is accepted.
  - hwdata loads wdata on that edge and is held through data-phase wait states.
  - Byte and halfword data are placed by the caller on the correct lanes; the block does no lane steering.
- Reads: rdata = hrdata and rdata_valid=1 on the cycle after each read data phase completes with hready=1 & hresp=0 (registered, 1-cycle latency). No rdata_valid for a beat that ends in ERROR.
- cmd_ready=0 outside IDLE. Commands are never overlapped; there is at least one IDLE bus cycle between commands.
- cmd_len=0 gives a SINGLE transfer: XFER→LAST directly.
- Reset mid-burst: htrans goes to IDLE immediately, nothing completes, and done is not pulsed.

Test Plan:
- Word write, cmd_addr=0x0010, len=0, wdata=0xDEADBEEF, zero-wait RAM slave:
  - htrans 10 for one cycle, hburst=000.
  - hwdata=0xDEADBEEF in the next cycle, done 1 cycle later with err=0.
  - A read-back command returns rdata=0xDEADBEEF.
- INCR4 read, cmd_addr=0x0100, len=3, size=2:
  - haddr 0x100/0x104/0x108/0x10C, htrans 10,11,11,11 on consecutive cycles.
  - Four rdata_valid pulses in order, then done.
- Byte INCR3 write, cmd_addr=0x0021, size=0: haddr 0x21/0x22/0x23, exactly 3 wdata_pop pulses.
- Wait-state slave (hready low 2 cycles on beat 2 of INCR4 write): haddr, htrans and hwdata stay stable during the stall, and total latency grows by exactly 2 cycles.
- ERROR on beat 2 of INCR4 read:
  - htrans=00 in the first ERROR cycle.
  - Beats 3–4 are never issued.
  - done=1 with err=1 in the second ERROR cycle.
  - Only one rdata_valid pulse (beat 1).
- hresetn low mid-INCR4 write: all outputs take reset values asynchronously, cmd_ready=1 after release, and a new command runs normally.
